// File: rtl/counter_8bit_pkg.sv
// Shared types and defaults for the counter_8bit stream source.
package counter_8bit_pkg;

  localparam int DATA_W = 8;

  typedef logic [DATA_W-1:0] data_t;

  localparam data_t DEFAULT_START = 8'h00;
  localparam data_t DEFAULT_STEP  = 8'h01;

  // Modulo-2^DATA_W increment; the carry out of the top bit is dropped.
  function automatic data_t next_value(data_t v, data_t step);
    return v + step;
  endfunction

endpackage

// File: rtl/stream_reg_slice.sv
// Generic valid/ready register slice with a one-entry skid buffer.
// Both output signals and the input-side ready come straight from flops,
// so no combinational path crosses the slice in either direction.
module stream_reg_slice #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             out_valid_q, out_valid_n;
  logic [WIDTH-1:0] out_data_q, out_data_n;
  logic             skid_valid_q, skid_valid_n;
  logic [WIDTH-1:0] skid_data_q, skid_data_n;
  logic             in_ready_q;

  // Next-state: refill the output stage from the skid entry first, otherwise
  // from the input; park an accepted input in the skid when the output stalls.
  always_comb begin
    out_valid_n  = out_valid_q;
    out_data_n   = out_data_q;
    skid_valid_n = skid_valid_q;
    skid_data_n  = skid_data_q;
    if (out_ready || !out_valid_q) begin
      if (skid_valid_q) begin
        out_valid_n  = 1'b1;
        out_data_n   = skid_data_q;
        skid_valid_n = 1'b0;
      end else begin
        out_valid_n = in_valid;
        if (in_valid) begin
          out_data_n = in_data;
        end
      end
    end else if (in_valid && in_ready_q) begin
      skid_valid_n = 1'b1;
      skid_data_n  = in_data;
    end
  end

  // Register all slice state; input ready is accepted only while the skid is free.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= RESET_DATA;
      skid_valid_q <= 1'b0;
      skid_data_q  <= RESET_DATA;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_n;
      out_data_q   <= out_data_n;
      skid_valid_q <= skid_valid_n;
      skid_data_q  <= skid_data_n;
      in_ready_q   <= !skid_valid_n;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/counter_8bit.sv
// Free-running incrementing sequence source on a valid/ready stream.
// Optional macro COUNTER_8BIT_OUTPUT_REG_EN inserts a registered output
// slice (stream_reg_slice), adding one cycle of first-valid latency.
module counter_8bit
  import counter_8bit_pkg::*;
#(
  parameter int               WIDTH = DATA_W,
  parameter logic [WIDTH-1:0] START = WIDTH'(DEFAULT_START),
  parameter logic [WIDTH-1:0] STEP  = WIDTH'(DEFAULT_STEP)
) (
  input  logic             clock,
  input  logic             reset,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_next;
  logic             cnt_valid;
  logic             cnt_ready;
  logic             cnt_fire;

  if (WIDTH == DATA_W) begin : g_pkg_add
    assign cnt_next = WIDTH'(next_value(data_t'(cnt), data_t'(STEP)));
  end else begin : g_wide_add
    assign cnt_next = cnt + STEP;
  end

  assign cnt_fire = cnt_valid && cnt_ready;

  // Sequence register and valid flag: valid comes up one edge after reset
  // release and stays up; the value only moves on an accepted transfer.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_valid <= 1'b0;
      cnt       <= START;
    end else begin
      cnt_valid <= 1'b1;
      if (cnt_fire) begin
        cnt <= cnt_next;
      end
    end
  end

`ifdef COUNTER_8BIT_OUTPUT_REG_EN
  stream_reg_slice #(
    .WIDTH      (WIDTH),
    .RESET_DATA (START)
  ) u_out_slice (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (cnt_valid),
    .in_ready  (cnt_ready),
    .in_data   (cnt),
    .out_valid (valid),
    .out_ready (ready),
    .out_data  (data)
  );
`else
  assign cnt_ready = ready;
  assign valid     = cnt_valid;
  assign data      = cnt;
`endif

endmodule

// File: tb/tb_counter_8bit.sv
// Self-checking bench for counter_8bit (either build of the output slice).
module tb_counter_8bit;

  localparam int START_V = 0;
  localparam int STEP_V  = 1;
`ifdef COUNTER_8BIT_OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       ready;
  logic       valid;
  logic [7:0] data;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int unsigned n_xfer       = 0;

  counter_8bit #(
    .WIDTH (8),
    .START (8'(START_V)),
    .STEP  (8'(STEP_V))
  ) dut (
    .clock (clock),
    .reset (reset),
    .valid (valid),
    .ready (ready),
    .data  (data)
  );

  always #5 clock = ~clock;

  // Expected n-th item of the stream: START + n*STEP modulo 256.
  function automatic logic [7:0] model_value(int unsigned n);
    return 8'((START_V + n * STEP_V) % 256);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    tests_run++;
    if (valid !== 1'b0 || data !== 8'(START_V)) begin
      tests_failed++;
      $display("FAIL reset_state: valid=%b data=%h, expected valid=0 data=%h", valid, data, 8'(START_V));
    end
    reset  = 1'b0;
    n_xfer = 0;
    for (int i = 1; i <= LAT; i++) begin
      @(negedge clock);
      tests_run++;
      if (i < LAT) begin
        if (valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL first_valid_early: valid=%b after %0d edges, expected 0", valid, i);
        end
      end else if (valid !== 1'b1 || data !== model_value(0)) begin
        tests_failed++;
        $display("FAIL first_valid: valid=%b data=%h after %0d edges, expected valid=1 data=%h", valid, data, i, model_value(0));
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      tests_run++;
      if (valid !== 1'b1 || data !== model_value(0)) begin
        tests_failed++;
        $display("FAIL initial_stall: valid=%b data=%h, expected valid=1 data=%h", valid, data, model_value(0));
      end
    end
  endtask

  task automatic test_full_rate();
    for (int i = 0; i < 300; i++) begin
      tests_run++;
      if (valid !== 1'b1 || data !== model_value(n_xfer)) begin
        tests_failed++;
        $display("FAIL full_rate[%0d]: valid=%b data=%h, expected valid=1 data=%h", i, valid, data, model_value(n_xfer));
      end
      ready = 1'b1;
      n_xfer++;
      @(negedge clock);
    end
  endtask

  task automatic test_random();
    int         got = 0;
    int         cycles = 0;
    logic       r;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    while (got < 1000 && cycles < 10000) begin
      r = ($urandom_range(0, 3) != 0);
      tests_run++;
      if (valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL random_valid: valid=%b at cycle %0d, expected 1", valid, cycles);
      end
      if (prev_stall) begin
        tests_run++;
        if (data !== prev_data) begin
          tests_failed++;
          $display("FAIL random_hold: data=%h, expected held %h", data, prev_data);
        end
      end
      if (valid === 1'b1 && r) begin
        tests_run++;
        if (data !== model_value(n_xfer)) begin
          tests_failed++;
          $display("FAIL random_xfer[%0d]: data=%h, expected %h", got, data, model_value(n_xfer));
        end
        n_xfer++;
        got++;
      end
      prev_stall = (valid === 1'b1) && !r;
      prev_data  = data;
      ready      = r;
      @(negedge clock);
      cycles++;
    end
    tests_run++;
    if (got != 1000) begin
      tests_failed++;
      $display("FAIL random_budget: %0d transfers in %0d cycles, expected 1000", got, cycles);
    end
  endtask

  task automatic test_stall_7f();
    int guard = 0;
    while (model_value(n_xfer) != 8'h7F && guard < 300) begin
      tests_run++;
      if (data !== model_value(n_xfer)) begin
        tests_failed++;
        $display("FAIL stall_approach: data=%h, expected %h", data, model_value(n_xfer));
      end
      ready = 1'b1;
      n_xfer++;
      guard++;
      @(negedge clock);
    end
    ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tests_run++;
      if (valid !== 1'b1 || data !== 8'h7F) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d]: valid=%b data=%h, expected valid=1 data=7f", i, valid, data);
      end
      @(negedge clock);
    end
    tests_run++;
    if (valid !== 1'b1 || data !== 8'h7F) begin
      tests_failed++;
      $display("FAIL stall_release: valid=%b data=%h, expected valid=1 data=7f", valid, data);
    end
    ready = 1'b1;
    n_xfer++;
    @(negedge clock);
    tests_run++;
    if (data !== model_value(n_xfer)) begin
      tests_failed++;
      $display("FAIL stall_after: data=%h, expected %h", data, model_value(n_xfer));
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    while (model_value(n_xfer) != 8'h42 && guard < 300) begin
      tests_run++;
      if (data !== model_value(n_xfer)) begin
        tests_failed++;
        $display("FAIL mid_approach: data=%h, expected %h", data, model_value(n_xfer));
      end
      ready = 1'b1;
      n_xfer++;
      guard++;
      @(negedge clock);
    end
    tests_run++;
    if (data !== 8'h42) begin
      tests_failed++;
      $display("FAIL mid_at42: data=%h, expected 42", data);
    end
    reset = 1'b1;
    ready = 1'b1;
    @(negedge clock);
    tests_run++;
    if (valid !== 1'b0 || data !== 8'(START_V)) begin
      tests_failed++;
      $display("FAIL mid_reset: valid=%b data=%h, expected valid=0 data=%h", valid, data, 8'(START_V));
    end
    @(negedge clock);
    reset  = 1'b0;
    n_xfer = 0;
    for (int i = 1; i <= LAT; i++) begin
      @(negedge clock);
      tests_run++;
      if (i < LAT) begin
        if (valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL mid_restart_early: valid=%b after %0d edges, expected 0", valid, i);
        end
      end else if (valid !== 1'b1 || data !== model_value(0)) begin
        tests_failed++;
        $display("FAIL mid_restart: valid=%b data=%h, expected valid=1 data=%h", valid, data, model_value(0));
      end
    end
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if (valid !== 1'b1 || data !== model_value(n_xfer)) begin
        tests_failed++;
        $display("FAIL mid_seq[%0d]: valid=%b data=%h, expected valid=1 data=%h", i, valid, data, model_value(n_xfer));
      end
      n_xfer++;
      @(negedge clock);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    ready = 1'b0;
    test_reset();
    test_full_rate();
    test_random();
    test_stall_7f();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
